// File: rtl/uart_tx.sv
// uart_tx: buffered 8-N-1 UART transmitter with a 2^FIFO_AW-entry FIFO.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8-E-1 frames).
module uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_AW = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         tx_data,
  input  logic               tx_valid,
  output logic               tx_ready,
  output logic               tx_busy,
  output logic [FIFO_AW:0]   fifo_count,
  output logic               txd
);
`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif
  localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [FIFO_AW:0] ONE = (FIFO_AW + 1)'(1);
  state_t state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic txd_q, txd_d;
  logic [FIFO_AW:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [7:0] mem [2**FIFO_AW];
  logic [7:0] head;
  logic empty, full, push, pop, tick;
`ifdef UART_TX_PARITY_EN
  logic par_q, par_d;
`endif
  assign empty = wptr_q == rptr_q;
  assign full = (wptr_q[FIFO_AW] != rptr_q[FIFO_AW]) && (wptr_q[FIFO_AW-1:0] == rptr_q[FIFO_AW-1:0]);
  assign push = tx_valid && !full;
  assign tick = cnt_q == LAST;
  assign head = mem[rptr_q[FIFO_AW-1:0]];
  assign tx_ready = !full;
  assign tx_busy = !empty || state_q != IDLE;
  assign fifo_count = wptr_q - rptr_q;
  assign txd = txd_q;
  always_comb begin
    state_d = state_q;
    cnt_d = tick ? '0 : cnt_q + 16'd1;
    bit_d = bit_q;
    shift_d = shift_q;
    pop = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        pop = !empty;
        state_d = empty ? IDLE : START;
      end
      START: state_d = tick ? DATA : START;
      DATA: if (tick) begin
        shift_d = shift_q >> 1;
        bit_d = bit_q + 3'd1;
`ifdef UART_TX_PARITY_EN
        if (bit_q == 3'd7) state_d = PARITY;
`else
        if (bit_q == 3'd7) state_d = STOP;
`endif
      end
`ifdef UART_TX_PARITY_EN
      PARITY: state_d = tick ? STOP : PARITY;
`endif
      STOP: if (tick) begin
        // back-to-back frames: reload straight into START with no idle bit
        pop = !empty;
        state_d = empty ? IDLE : START;
      end
      default: state_d = IDLE;
    endcase
    if (pop) shift_d = head;
    wptr_d = push ? wptr_q + ONE : wptr_q;
    rptr_d = pop ? rptr_q + ONE : rptr_q;
`ifdef UART_TX_PARITY_EN
    par_d = pop ? ^head : par_q;
    txd_d = state_d == START ? 1'b0 : state_d == DATA ? shift_d[0] : state_d == PARITY ? par_d : 1'b1;
`else
    txd_d = state_d == START ? 1'b0 : state_d == DATA ? shift_d[0] : 1'b1;
`endif
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      bit_q <= '0;
      shift_q <= '0;
      txd_q <= 1'b1;
      wptr_q <= '0;
      rptr_q <= '0;
`ifdef UART_TX_PARITY_EN
      par_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      shift_q <= shift_d;
      txd_q <= txd_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
`ifdef UART_TX_PARITY_EN
      par_q <= par_d;
`endif
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wptr_q[FIFO_AW-1:0]] <= tx_data;
  end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: scoreboard bench; a line decoder checks every serial frame against queued bytes.
module tb_uart_tx;
  localparam int C = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 10;
  localparam bit PAR = 1'b1;
`else
  localparam int NB = 9;
  localparam bit PAR = 1'b0;
`endif
  localparam int FRAME = (NB + 1) * C;
  logic clk = 1'b0, rst_n = 1'b0, tx_valid = 1'b0, tx_ready, tx_busy, txd;
  logic [7:0] tx_data = '0;
  logic [4:0] fifo_count;
  int n_tests = 0, n_fail = 0, cyc_n = 0;
  logic [7:0] exp_q[$];
  int starts[$];
  uart_tx #(.CLKS_PER_BIT(C), .FIFO_AW(4)) dut (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_busy(tx_busy), .fifo_count(fifo_count), .txd(txd)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string name, input int got, input int want);
    n_tests++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, want, cyc_n);
    end
  endtask
  // Frame bit at position idx: start, 8 data LSB-first, optional even parity, stop.
  function automatic logic fbit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    if (PAR && idx == 9) return ^b;
    return 1'b1;
  endfunction
  // Line monitor: detect start edge, sample mid-bit, compare against scoreboard.
  logic rx [0:NB];
  bit m_act = 0;
  int m_pos = 0;
  always @(negedge clk) begin
    if (!rst_n) m_act = 0;
    else if (!m_act) begin
      if (txd == 1'b0) begin
        m_act = 1;
        m_pos = 0;
        starts.push_back(cyc_n);
      end
    end else m_pos++;
    if (rst_n && m_act && m_pos % C == C / 2) begin
      rx[m_pos / C] = txd;
      if (m_pos / C == NB) begin
        logic [7:0] got, want;
        m_act = 0;
        for (int i = 0; i < 8; i++) got[i] = rx[i+1];
        if (exp_q.size() == 0) chk("unexpected_frame", int'(got), -1);
        else begin
          want = exp_q.pop_front();
          chk("frame_byte", int'(got), int'(want));
          chk("frame_start", int'(rx[0]), 0);
          chk("frame_stop", int'(rx[NB]), 1);
          if (PAR) chk("frame_parity", int'(rx[9]), int'(^want));
        end
      end
    end
  end
  task automatic step();
    logic a;
    logic [7:0] d;
    a = tx_valid && tx_ready && rst_n;
    d = tx_data;
    @(posedge clk);
    if (a) exp_q.push_back(d);
    #1;
  endtask
  task automatic wr(input logic [7:0] b);
    int n = 0;
    tx_data = b;
    tx_valid = 1'b1;
    while (!tx_ready && n < 5000) begin step(); n++; end
    if (n == 5000) chk("wr_timeout", n, 0);
    step();
    tx_valid = 1'b0;
  endtask
  task automatic wait_idle();
    int n = 0;
    while ((tx_busy || exp_q.size() != 0) && n < 5000) begin step(); n++; end
    if (n == 5000) chk("drain_timeout", n, 0);
    repeat (3) step();
  endtask
  initial begin
    int n, nb, lows;
    logic pre;
    #12;
    chk("rst_txd", int'(txd), 1);
    chk("rst_ready", int'(tx_ready), 1);
    chk("rst_busy", int'(tx_busy), 0);
    chk("rst_count", int'(fifo_count), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) step();
    chk("idle_txd", int'(txd), 1);
    // single 0x55 frame: latency, bit pattern, busy fall
    wr(8'h55);
    chk("acc_txd", int'(txd), 1);
    chk("acc_busy", int'(tx_busy), 1);
    chk("acc_count", int'(fifo_count), 1);
    n = 0;
    do begin
      step();
      n++;
      if (n == 1) chk("pop_count", int'(fifo_count), 0);
      if (n <= FRAME) chk("bit_55", int'(txd), int'(fbit(8'h55, (n - 1) / C)));
    end while (tx_busy && n < 200);
    chk("busy_fall", n, FRAME + 1);
    chk("after_txd", int'(txd), 1);
    wait_idle();
    // back-to-back 0xA3, 0x0F
    starts.delete();
    tx_data = 8'hA3; tx_valid = 1'b1;
    step();
    tx_data = 8'h0F;
    step();
    tx_valid = 1'b0;
    chk("b2b_count1", int'(fifo_count), 1);
    repeat (FRAME - 1) step();
    chk("b2b_count_hold", int'(fifo_count), 1);
    step();
    chk("b2b_count0", int'(fifo_count), 0);
    wait_idle();
    chk("b2b_frames", starts.size(), 2);
    if (starts.size() == 2) chk("b2b_gap", starts[1] - starts[0], FRAME);
    // stalled line with valid held: only 17 bytes fit
    nb = 0;
    tx_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tx_data = 8'(nb);
      pre = tx_ready;
      step();
      if (pre) nb++;
    end
    chk("stall_accepted", nb, 17);
    chk("stall_ready", int'(tx_ready), 0);
    chk("stall_count", int'(fifo_count), 16);
    tx_data = 8'(nb);
    n = 0;
    while (fifo_count == 5'd16 && n < 100) begin step(); n++; end
    chk("full_pop_count", int'(fifo_count), 15);
    chk("full_pop_ready", int'(tx_ready), 1);
    step();
    tx_valid = 1'b0;
    chk("refill_count", int'(fifo_count), 16);
    wait_idle();
    // reset during bit 3 of 0xFF with another byte queued
    wr(8'hFF);
    wr(8'h12);
    repeat (17) step();
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_txd", int'(txd), 1);
    chk("mid_rst_count", int'(fifo_count), 0);
    chk("mid_rst_busy", int'(tx_busy), 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    lows = 0;
    for (int i = 0; i < 60; i++) begin step(); if (!txd || tx_busy) lows++; end
    chk("post_rst_quiet", lows, 0);
    wr(8'h01);
    wait_idle();
`ifdef UART_TX_PARITY_EN
    wr(8'h07);
    wr(8'h03);
    wait_idle();
`endif
    // randomized traffic with random gaps
    for (int i = 0; i < 25; i++) begin
      repeat ($urandom_range(0, 50)) step();
      wr(8'($urandom));
    end
    wait_idle();
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
